// File: rtl/spi_xip_seq_pkg.sv
// Shared constants for the SPI XIP read sequencer.
// Register offsets, flash command, sequencer states.
package spi_xip_seq_pkg;

  localparam logic [7:0] RegCsid   = 8'h10;
  localparam logic [7:0] RegCsmode = 8'h18;
  localparam logic [7:0] RegTxdata = 8'h48;
  localparam logic [7:0] RegRxdata = 8'h4C;
  localparam logic [7:0] CmdRead   = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CSID,
    CSHOLD,
    TXWR,
    RXRD,
    CSREL,
    RESP
  } state_t;

  // Byte idx of the 8-byte TX frame: read cmd, 24-bit address, 4 dummies.
  function automatic logic [7:0] txByte(
    input logic [2:0]  idx,
    input logic [23:0] a
  );
    case (idx)
      3'd0:    return CmdRead;
      3'd1:    return a[23:16];
      3'd2:    return a[15:8];
      3'd3:    return a[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_xip_apb_master.sv
// Single-transfer APB master: setup, access until PREADY, one idle cycle.
// A new start is taken whenever PSEL is low.
module spi_xip_apb_master (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic        wr,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        idle,
  output logic        done,
  output logic [31:0] rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else if (!PSEL) begin
      if (start) begin
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PWRITE  <= wr;
        PADDR   <= addr;
        PWDATA  <= wdata;
      end
    end else if (!PENABLE) begin
      PENABLE <= 1'b1;
    end else if (PREADY) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
    end
  end

  assign idle  = !PSEL;
  assign done  = PSEL && PENABLE && PREADY;
  assign rdata = PRDATA;
  assign PSTRB = 4'hF;

endmodule

// File: rtl/spi_xip_seq.sv
// XIP read sequencer: one 24-bit address in, one 32-bit word out via APB SPI.
// Define SPI_XIP_TIMEOUT_EN to bound RX polling by POLL_LIMIT.
module spi_xip_seq
  import spi_xip_seq_pkg::*;
#(
  parameter int POLL_LIMIT = 255,
  parameter int CS_ID      = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [23:0] ReqAddr,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  localparam logic [7:0] PollLast = 8'(POLL_LIMIT - 1);

  state_t      state;
  logic [23:0] addrQ;
  logic [2:0]  cnt;
  logic        respValid;
  logic [31:0] respData;
  logic        respErr;
`ifdef SPI_XIP_TIMEOUT_EN
  logic [7:0]  pollCnt;
`endif

  logic        busy;
  logic        cmdWr;
  logic [7:0]  cmdAddr;
  logic [31:0] cmdData;
  logic        mIdle;
  logic        mDone;
  logic [31:0] rdata;
  logic        unusedSig;

  always_comb begin
    busy    = 1'b1;
    cmdWr   = 1'b1;
    cmdAddr = RegCsid;
    cmdData = 32'(CS_ID);
    case (state)
      CSID:   ;
      CSHOLD: begin
        cmdAddr = RegCsmode;
        cmdData = 32'd2;
      end
      TXWR: begin
        cmdAddr = RegTxdata;
        cmdData = {24'h0, txByte(cnt, addrQ)};
      end
      RXRD: begin
        cmdWr   = 1'b0;
        cmdAddr = RegRxdata;
        cmdData = '0;
      end
      CSREL: begin
        cmdAddr = RegCsmode;
        cmdData = '0;
      end
      default: busy = 1'b0;
    endcase
  end

  spi_xip_apb_master u_apb (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .start   (busy && mIdle),
    .wr      (cmdWr),
    .addr    (cmdAddr),
    .wdata   (cmdData),
    .idle    (mIdle),
    .done    (mDone),
    .rdata   (rdata),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      addrQ     <= '0;
      cnt       <= '0;
      respValid <= 1'b0;
      respData  <= '0;
      respErr   <= 1'b0;
`ifdef SPI_XIP_TIMEOUT_EN
      pollCnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (ReqValid) begin
          addrQ    <= ReqAddr;
          respData <= '0;
          respErr  <= 1'b0;
          state    <= CSID;
        end
        CSID:   if (mDone) state <= CSHOLD;
        CSHOLD: if (mDone) state <= TXWR;
        TXWR: if (mDone) begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= RXRD;
        end
        RXRD: if (mDone) begin
          if (rdata[31]) begin
`ifdef SPI_XIP_TIMEOUT_EN
            if (pollCnt == PollLast) begin
              state    <= CSREL;
              cnt      <= '0;
              pollCnt  <= '0;
              respErr  <= 1'b1;
              respData <= '0;
            end else begin
              pollCnt <= pollCnt + 8'd1;
            end
`endif
          end else begin
`ifdef SPI_XIP_TIMEOUT_EN
            pollCnt <= '0;
`endif
            cnt <= cnt + 3'd1;
            // Bytes 0..3 are the dummy phase; keep 4..7 little-endian.
            if (cnt[2]) respData[{cnt[1:0], 3'b000} +: 8] <= rdata[7:0];
            if (cnt == 3'd7) state <= CSREL;
          end
        end
        CSREL: if (mDone) state <= RESP;
        RESP: begin
          if (!respValid) begin
            respValid <= 1'b1;
          end else if (RespReady) begin
            respValid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ReqReady  = (state == IDLE);
  assign RespValid = respValid;
  assign RespData  = respData;
  assign RespErr   = respErr;
  assign unusedSig = ^{rdata[30:8], PollLast};

endmodule
